// File: rtl/board_io_pkg.sv
// Shared types and constants for the board input conditioning path.
package board_io_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } db_state_e;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_D = 3;
    localparam int unsigned BTN_R = 4;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, tick-driven debounce FSM, level and edge pulses.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, rise_q, fall_q;
    logic             commit_hi, commit_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (level_q | commit_hi) & ~commit_lo;
            rise_q  <= commit_hi;
            fall_q  <= commit_lo;
        end
    end

    // cnt counts ticks already spent pending; the DEBOUNCE_TICKS-th differing tick commits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit_hi = 1'b0;
        commit_lo = 1'b0;
        if (tick) begin
            unique case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = STABLE_HI;
                            commit_hi = 1'b1;
                        end else begin
                            state_d = PEND_HI;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (!sync2_q) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = STABLE_HI;
                        cnt_d     = '0;
                        commit_hi = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = STABLE_LO;
                            commit_lo = 1'b1;
                        end else begin
                            state_d = PEND_LO;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (sync2_q) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = STABLE_LO;
                        cnt_d     = '0;
                        commit_lo = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Synchronises and debounces board switches and buttons; adds press/release pulses and
// sticky write-1-to-clear press flags.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned N_SW           = 16,
    parameter int unsigned N_BTN          = 5,
    parameter int unsigned TICK_DIV       = 10000,
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_event_o,
    input  logic [N_BTN-1:0] evt_clr_i,
    output logic             evt_pending_o
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Switch edges are not exported.
    logic [N_SW-1:0] unused_sw_rise, unused_sw_fall;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .pin  (sw_i[i]),
            .level(sw_o[i]),
            .rise (unused_sw_rise[i]),
            .fall (unused_sw_fall[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .pin  (btn_i[i]),
            .level(btn_level_o[i]),
            .rise (btn_press_o[i]),
            .fall (btn_release_o[i])
        );
    end

    logic [N_BTN-1:0] event_q;
    logic             pending_q;

    // A press in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            event_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            event_q   <= btn_press_o | (event_q & ~evt_clr_i);
            pending_q <= |event_q;
        end
    end

    assign btn_event_o   = event_q;
    assign evt_pending_o = pending_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every output cycle by cycle.
module tb_board_input_conditioner;

    localparam int unsigned TD  = 4;
    localparam int unsigned DT  = 3;
    localparam int unsigned NS  = 16;
    localparam int unsigned NB  = 5;
    localparam int unsigned NCH = NS + NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] sw_i = '0;
    logic [NB-1:0] btn_i = '0;
    logic [NB-1:0] evt_clr_i = '0;
    logic [NS-1:0] sw_o;
    logic [NB-1:0] btn_level_o, btn_press_o, btn_release_o, btn_event_o;
    logic          evt_pending_o;

    board_input_conditioner #(
        .N_SW          (NS),
        .N_BTN         (NB),
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_i         (sw_i),
        .btn_i        (btn_i),
        .sw_o         (sw_o),
        .btn_level_o  (btn_level_o),
        .btn_press_o  (btn_press_o),
        .btn_release_o(btn_release_o),
        .btn_event_o  (btn_event_o),
        .evt_clr_i    (evt_clr_i),
        .evt_pending_o(evt_pending_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS-1:0] sw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] evt;
        logic          pend;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a level flips once the last DT tick samples since reset all differ.
    int unsigned   n_edges = 0;
    logic [NCH-1:0] pin_d1 = '0, pin_d2 = '0;
    int unsigned   samp[NCH];
    int unsigned   nsamp[NCH];
    logic [NCH-1:0] m_level = '0;
    logic [NB-1:0] m_press = '0, m_rel = '0, m_evt = '0;
    logic          m_pend = 1'b0;

    always @(posedge clk) begin : model
        logic [NCH-1:0] pins, sync_now;
        logic [NB-1:0]  evt_next;
        logic           tick_now, differ;
        int unsigned    mask, w;
        out_t           o;
        pins = {btn_i, sw_i};
        if (!rst_n) begin
            n_edges = 0;
            pin_d1  = '0;
            pin_d2  = '0;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_evt   = '0;
            m_pend  = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                samp[ch]  = 0;
                nsamp[ch] = 0;
            end
        end else begin
            evt_next = m_press | (m_evt & ~evt_clr_i);
            m_pend   = |m_evt;
            m_evt    = evt_next;
            tick_now = (n_edges % TD) == TD - 1;
            n_edges++;
            sync_now = pin_d2;
            pin_d2   = pin_d1;
            pin_d1   = pins;
            m_press  = '0;
            m_rel    = '0;
            if (tick_now) begin
                mask = (1 << DT) - 1;
                for (int ch = 0; ch < NCH; ch++) begin
                    samp[ch] = (samp[ch] << 1) | 32'(sync_now[ch]);
                    if (nsamp[ch] < DT) nsamp[ch]++;
                    w      = samp[ch] & mask;
                    differ = m_level[ch] ? (w == 0) : (w == mask);
                    if (nsamp[ch] == DT && differ) begin
                        m_level[ch] = ~m_level[ch];
                        if (ch >= NS) begin
                            if (m_level[ch]) m_press[ch-NS] = 1'b1;
                            else             m_rel[ch-NS]   = 1'b1;
                        end
                    end
                end
            end
        end
        o.sw   = m_level[NS-1:0];
        o.lvl  = m_level[NCH-1:NS];
        o.prs  = m_press;
        o.rel  = m_rel;
        o.evt  = m_evt;
        o.pend = m_pend;
        exp_q.push_back(o);
    end

    always @(negedge clk) begin : monitor
        out_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            check("sb_sw_o", 32'(sw_o), 32'(e.sw));
            check("sb_btn_level_o", 32'(btn_level_o), 32'(e.lvl));
            check("sb_btn_press_o", 32'(btn_press_o), 32'(e.prs));
            check("sb_btn_release_o", 32'(btn_release_o), 32'(e.rel));
            check("sb_btn_event_o", 32'(btn_event_o), 32'(e.evt));
            check("sb_evt_pending_o", 32'(evt_pending_o), 32'(e.pend));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int rel_cnt;
        int rst_hold;
        logic found;

        // Reset with switches high.
        rst_n = 1'b0;
        sw_i  = '1;
        step(5);
        check("rst_sw_o_in_reset", 32'(sw_o), 32'h0);
        rst_n = 1'b1;
        step(1);
        check("rst_sw_o", 32'(sw_o), 32'h0);
        check("rst_btn_level_o", 32'(btn_level_o), 32'h0);
        check("rst_btn_event_o", 32'(btn_event_o), 32'h0);
        check("rst_evt_pending_o", 32'(evt_pending_o), 32'h0);

        // Clean press on C.
        btn_i[0] = 1'b1;
        lat = 0;
        while (btn_level_o[0] !== 1'b1 && lat < 40) begin
            step(1);
            lat++;
        end
        checks++;
        if (lat < 11 || lat > 15) begin
            errors++;
            $display("FAIL press_latency: got %0d cycles, want 11..15", lat);
        end
        check("press_pulse_on", 32'(btn_press_o[0]), 32'h1);
        step(1);
        check("press_pulse_off", 32'(btn_press_o[0]), 32'h0);
        check("press_event_set", 32'(btn_event_o[0]), 32'h1);
        step(1);
        check("press_pending", 32'(evt_pending_o), 32'h1);

        // Six-cycle glitch on U is rejected.
        btn_i[1] = 1'b1;
        step(6);
        btn_i[1] = 1'b0;
        step(20);
        check("glitch_level", 32'(btn_level_o[1]), 32'h0);
        check("glitch_event", 32'(btn_event_o[1]), 32'h0);

        // Press, release and clear on L.
        btn_i[2] = 1'b1;
        step(20);
        check("l_level_high", 32'(btn_level_o[2]), 32'h1);
        btn_i[2] = 1'b0;
        rel_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (btn_release_o[2] === 1'b1) rel_cnt++;
        end
        check("l_release_once", 32'(rel_cnt), 32'h1);
        evt_clr_i[2] = 1'b1;
        step(1);
        evt_clr_i[2] = 1'b0;
        check("l_event_cleared", 32'(btn_event_o[2]), 32'h0);

        // Clear collides with the press pulse on D.
        btn_i[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (m_press[3]) found = 1'b1;
        end
        check("d_press_seen", 32'(found), 32'h1);
        evt_clr_i[3] = 1'b1;
        step(1);
        evt_clr_i[3] = 1'b0;
        check("d_collision_event", 32'(btn_event_o[3]), 32'h1);
        step(3);
        check("d_event_held", 32'(btn_event_o[3]), 32'h1);

        // Reset in the middle of a switch debounce.
        sw_i = '0;
        step(20);
        check("sw_settled_low", 32'(sw_o), 32'h0);
        sw_i = 16'h00A5;
        step(10);
        rst_n = 1'b0;
        step(3);
        check("mid_rst_sw_o", 32'(sw_o), 32'h0);
        rst_n = 1'b1;
        step(15);
        check("mid_rst_sw_after", 32'(sw_o), 32'h00A5);

        // R toggles every tick period and must never commit.
        btn_i[4] = 1'b0;
        step(20);
        for (int i = 0; i < 16; i++) begin
            btn_i[4] = ~btn_i[4];
            step(TD);
        end
        check("toggle_no_commit", 32'(btn_level_o[4]), 32'h0);

        // Randomised traffic.
        rst_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [NCH-1:0] pins;
            pins = {btn_i, sw_i};
            for (int b = 0; b < NCH; b++) begin
                if ($urandom_range(0, 15) == 0) pins[b] = ~pins[b];
            end
            {btn_i, sw_i} = pins;
            evt_clr_i = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
            rst_n = (rst_hold == 0);
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 599) == 0) rst_hold = $urandom_range(1, 3);
            step(1);
        end
        rst_n     = 1'b1;
        evt_clr_i = '0;
        step(5);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        check("monitor_active", 32'(pops > 4000), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
